// File: rtl/float_pkg.sv
// Float format constants shared by the float pixel-pipeline operator blocks.
// Combinational helpers only; no state and no latency.
// No flow control; the helpers are evaluated at elaboration time.
//
// Contents:
//   fmt_exp_w / fmt_man_w / fmt_bias : per-width IEEE-754 field geometry
//   fmt_legal                        : only binary32 and binary64 are supported
//   FLOAT_255_64 / FLOAT_255_32      : 255.0, the upper bound of the float clamp stage
package float_pkg;

    localparam int EXP_W_64 = 11;
    localparam int MAN_W_64 = 52;
    localparam int BIAS_64  = 1023;

    localparam int EXP_W_32 = 8;
    localparam int MAN_W_32 = 23;
    localparam int BIAS_32  = 127;

    localparam logic [63:0] FLOAT_255_64 = 64'h406FE00000000000;
    localparam logic [31:0] FLOAT_255_32 = 32'h437F0000;

    function automatic bit fmt_legal(input int size);
        return (size == 64) || (size == 32);
    endfunction

    function automatic int fmt_exp_w(input int size);
        return (size == 32) ? EXP_W_32 : EXP_W_64;
    endfunction

    function automatic int fmt_man_w(input int size);
        return (size == 32) ? MAN_W_32 : MAN_W_64;
    endfunction

    function automatic int fmt_bias(input int size);
        return (size == 32) ? BIAS_32 : BIAS_64;
    endfunction

endpackage

// File: rtl/uint8_to_float_lzc8.sv
// 8-bit leading-one priority encoder.
// Purely combinational, zero latency.
// No flow control.
//
// Ports:
//   i_dat  : value to scan
//   o_pos  : bit index of the most significant set bit (0 when the input is 0)
//   o_zero : input is all zeros
module lzc8 (
    input  logic [7:0] i_dat,
    output logic [2:0] o_pos,
    output logic       o_zero
);

    always_comb begin
        o_pos  = 3'd0;
        o_zero = 1'b0;
        casez (i_dat)
            8'b1???????: o_pos = 3'd7;
            8'b01??????: o_pos = 3'd6;
            8'b001?????: o_pos = 3'd5;
            8'b0001????: o_pos = 3'd4;
            8'b00001???: o_pos = 3'd3;
            8'b000001??: o_pos = 3'd2;
            8'b0000001?: o_pos = 3'd1;
            8'b00000001: o_pos = 3'd0;
            default:     o_zero = 1'b1;
        endcase
    end

endmodule

// File: rtl/uint8_to_float.sv
// Converts an unsigned 8-bit pixel value into an exact IEEE-754 float of width SIZE.
// Latency 2 cycles input handshake to result valid; 1 beat/cycle throughput.
// Full backpressure: two beats held internally, s_axis_a_tready is combinational from m_axis_result_tready.
//
// Ports:
//   aclk, aresetn                     : clock, asynchronous active-low reset
//   s_axis_a_tdata/tvalid/tready      : 8-bit unsigned input stream
//   m_axis_result_tdata/tvalid/tready : SIZE-bit float result stream
module uint8_to_float
    import float_pkg::*;
#(
    parameter int SIZE = 64
) (
    input  logic            aclk,
    input  logic            aresetn,
    input  logic [7:0]      s_axis_a_tdata,
    input  logic            s_axis_a_tvalid,
    output logic            s_axis_a_tready,
    output logic [SIZE-1:0] m_axis_result_tdata,
    output logic            m_axis_result_tvalid,
    input  logic            m_axis_result_tready
);

    localparam int EXP_W = fmt_exp_w(SIZE);
    localparam int MAN_W = fmt_man_w(SIZE);
    localparam int BIAS  = fmt_bias(SIZE);

    generate
        if (!fmt_legal(SIZE)) begin : g_bad_size
            $error("uint8_to_float: SIZE must be 32 or 64");
        end
    endgenerate

    // Stage 1 state
    logic            r_v1;
    logic [7:0]      r_d1;
    logic [2:0]      r_p1;
    logic            r_z1;

    // Stage 2 state (drives the output port directly)
    logic            r_v2;
    logic [SIZE-1:0] r_d2;

    logic            w_adv1;
    logic            w_adv2;
    logic [2:0]      w_pos;
    logic            w_zero;
    logic [EXP_W-1:0] w_exp;
    logic [7:0]      w_man8;
    logic [SIZE-1:0] w_res;

    // A stage may load whenever it is empty or its contents move on this edge.
    assign w_adv2 = !r_v2 || m_axis_result_tready;
    assign w_adv1 = !r_v1 || w_adv2;

    assign s_axis_a_tready      = w_adv1;
    assign m_axis_result_tvalid = r_v2;
    assign m_axis_result_tdata  = r_d2;

    lzc8 u_lzc8 (
        .i_dat  (s_axis_a_tdata),
        .o_pos  (w_pos),
        .o_zero (w_zero)
    );

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_v1 <= 1'b0;
            r_d1 <= 8'd0;
            r_p1 <= 3'd0;
            r_z1 <= 1'b0;
        end else if (w_adv1) begin
            r_v1 <= s_axis_a_tvalid;
            r_d1 <= s_axis_a_tdata;
            r_p1 <= w_pos;
            r_z1 <= w_zero;
        end
    end

    // Unbiased exponent equals the leading-one position, so no normalisation loop.
    assign w_exp = EXP_W'(BIAS) + EXP_W'(r_p1);

    // Shifting the leading one out of the 8-bit field leaves the fraction bits
    // left-justified; a shift of 8 (value 1) yields an empty fraction.
    assign w_man8 = r_d1 << (4'd8 - {1'b0, r_p1});

    // Every 8-bit value fits in the fraction exactly, so the low bits are zero.
    assign w_res = r_z1 ? '0 : {1'b0, w_exp, w_man8, {(MAN_W-8){1'b0}}};

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_v2 <= 1'b0;
            r_d2 <= '0;
        end else if (w_adv2) begin
            r_v2 <= r_v1;
            r_d2 <= w_res;
        end
    end

endmodule

// File: tb/tb_uint8_to_float.sv
module tb_uint8_to_float;

    logic        aclk = 1'b0;
    always #5 aclk = ~aclk;

    // SIZE=64 instance
    logic        rst_n;
    logic [7:0]  s_dat;
    logic        s_vld;
    logic        s_rdy;
    logic [63:0] m_dat;
    logic        m_vld;
    logic        m_rdy;

    // SIZE=32 instance
    logic        b_rst_n;
    logic [7:0]  b_s_dat;
    logic        b_s_vld;
    logic        b_s_rdy;
    logic [31:0] b_m_dat;
    logic        b_m_vld;
    logic        b_m_rdy;

    uint8_to_float #(.SIZE(64)) dut64 (
        .aclk                 (aclk),
        .aresetn              (rst_n),
        .s_axis_a_tdata       (s_dat),
        .s_axis_a_tvalid      (s_vld),
        .s_axis_a_tready      (s_rdy),
        .m_axis_result_tdata  (m_dat),
        .m_axis_result_tvalid (m_vld),
        .m_axis_result_tready (m_rdy)
    );

    uint8_to_float #(.SIZE(32)) dut32 (
        .aclk                 (aclk),
        .aresetn              (b_rst_n),
        .s_axis_a_tdata       (b_s_dat),
        .s_axis_a_tvalid      (b_s_vld),
        .s_axis_a_tready      (b_s_rdy),
        .m_axis_result_tdata  (b_m_dat),
        .m_axis_result_tvalid (b_m_vld),
        .m_axis_result_tready (b_m_rdy)
    );

    typedef struct {
        logic [7:0]  din;
        logic [63:0] dout;
    } vec_t;

    vec_t t64[5];
    vec_t t32[4];

    int n_chk  = 0;
    int n_pass = 0;

    // Scoreboard state for the 64-bit streaming tests
    logic [7:0]  send_q[$];
    logic [63:0] exp_q[$];
    int          got;
    logic        held;
    logic [63:0] held_dat;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_chk++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %h want %h", name, act, req);
    endtask

    // One clock of the 64-bit stream. vld_mode/rdy_mode: 0 low, 1 high, 2 random.
    task automatic cycle64(input int vld_mode, input int rdy_mode);
        logic want_vld;
        @(posedge aclk);
        #1;
        if (rdy_mode == 2) m_rdy = 1'($urandom_range(0, 1));
        else               m_rdy = (rdy_mode == 1);
        want_vld = (vld_mode == 1) || (vld_mode == 2 && $urandom_range(0, 1) == 1);
        if (send_q.size() > 0 && want_vld) begin
            s_vld = 1'b1;
            s_dat = send_q[0];
        end else begin
            s_vld = 1'b0;
        end
        @(negedge aclk);
        if (held) begin
            check("hold_vld", {63'd0, m_vld}, 64'd1);
            check("hold_dat", m_dat, held_dat);
        end
        if (s_vld && s_rdy) begin
            exp_q.push_back($realtobits(real'(int'(send_q[0]))));
            void'(send_q.pop_front());
        end
        if (m_vld && m_rdy) begin
            got++;
            if (exp_q.size() == 0) begin
                n_chk++;
                $display("FAIL stray_out: got %h want no beat", m_dat);
            end else begin
                check("out_dat", m_dat, exp_q.pop_front());
            end
        end
        held     = m_vld && !m_rdy;
        held_dat = m_dat;
    endtask

    task automatic run64(input int vld_mode, input int rdy_mode, input int budget);
        int left;
        left = budget;
        while ((send_q.size() > 0 || exp_q.size() > 0) && left > 0) begin
            cycle64(vld_mode, rdy_mode);
            left--;
        end
        check("drain_left", 64'(send_q.size() + exp_q.size()), 64'd0);
    endtask

    initial begin
        int got0;
        logic exp_v;

        t64[0] = '{8'd0,   64'h0000000000000000};
        t64[1] = '{8'd1,   64'h3FF0000000000000};
        t64[2] = '{8'd3,   64'h4008000000000000};
        t64[3] = '{8'd128, 64'h4060000000000000};
        t64[4] = '{8'd255, 64'h406FE00000000000};
        t32[0] = '{8'd1,   64'h3F800000};
        t32[1] = '{8'd2,   64'h40000000};
        t32[2] = '{8'd255, 64'h437F0000};
        t32[3] = '{8'd0,   64'h00000000};

        rst_n = 1'b0; s_vld = 1'b0; s_dat = 8'd0; m_rdy = 1'b0;
        b_rst_n = 1'b0; b_s_vld = 1'b0; b_s_dat = 8'd0; b_m_rdy = 1'b0;
        held = 1'b0; got = 0;

        // Reset state
        #12;
        check("rst_vld64", {63'd0, m_vld}, 64'd0);
        check("rst_dat64", m_dat, 64'd0);
        check("rst_vld32", {63'd0, b_m_vld}, 64'd0);
        check("rst_dat32", {32'd0, b_m_dat}, 64'd0);
        @(negedge aclk);
        rst_n = 1'b1; b_rst_n = 1'b1;
        #1;
        check("rst_rdy64", {63'd0, s_rdy}, 64'd1);
        check("rst_rdy32", {63'd0, b_s_rdy}, 64'd1);

        // SIZE=64 back-to-back stream, 2-cycle latency, full-pipeline simultaneous handshake
        m_rdy = 1'b1;
        for (int j = 0; j < 8; j++) begin
            @(posedge aclk);
            #1;
            if (j < 5) begin s_vld = 1'b1; s_dat = t64[j].din; end
            else s_vld = 1'b0;
            @(negedge aclk);
            exp_v = (j >= 2) && (j < 7);
            check("t64_vld", {63'd0, m_vld}, {63'd0, exp_v});
            if (exp_v) check("t64_dat", m_dat, t64[j-2].dout);
            if (j >= 2 && j <= 4) check("t64_full_rdy", {63'd0, s_rdy}, 64'd1);
        end

        // SIZE=32 stream
        b_m_rdy = 1'b1;
        for (int j = 0; j < 7; j++) begin
            @(posedge aclk);
            #1;
            if (j < 4) begin b_s_vld = 1'b1; b_s_dat = t32[j].din; end
            else b_s_vld = 1'b0;
            @(negedge aclk);
            exp_v = (j >= 2) && (j < 6);
            check("t32_vld", {63'd0, b_m_vld}, {63'd0, exp_v});
            if (exp_v) check("t32_dat", {32'd0, b_m_dat}, t32[j-2].dout);
        end

        // Backpressure: only two beats fit while the output is stalled
        held = 1'b0; got0 = got;
        send_q = '{8'd10, 8'd20, 8'd30, 8'd40};
        for (int k = 0; k < 5; k++) cycle64(1, 0);
        check("bp_rdy", {63'd0, s_rdy}, 64'd0);
        check("bp_accepted", 64'(exp_q.size()), 64'd2);
        check("bp_head_vld", {63'd0, m_vld}, 64'd1);
        check("bp_head_dat", m_dat, 64'h4024000000000000);
        run64(1, 1, 50);
        check("bp_count", 64'(got - got0), 64'd4);

        // Random valid/ready over every input value
        held = 1'b0; got0 = got;
        for (int v = 0; v < 256; v++) send_q.push_back(8'(v));
        run64(2, 2, 5000);
        check("rand_count", 64'(got - got0), 64'd256);

        // Asynchronous reset with two beats in flight
        held = 1'b0;
        send_q = '{8'd50, 8'd60};
        for (int k = 0; k < 3; k++) cycle64(1, 0);
        @(posedge aclk);
        #3;
        rst_n = 1'b0;
        #1;
        check("mid_rst_vld", {63'd0, m_vld}, 64'd0);
        check("mid_rst_dat", m_dat, 64'd0);
        send_q.delete(); exp_q.delete(); held = 1'b0; s_vld = 1'b0;
        @(posedge aclk);
        #1;
        check("in_rst_vld", {63'd0, m_vld}, 64'd0);
        @(negedge aclk);
        #2;
        rst_n = 1'b1;
        #1;
        check("post_rst_rdy", {63'd0, s_rdy}, 64'd1);
        got0 = got;
        send_q = '{8'd7};
        exp_q.delete();
        run64(1, 1, 20);
        check("post_rst_count", 64'(got - got0), 64'd1);
        // exp_q held only 7, so the single output above was checked as 0x401C000000000000
        check("seven_ref", $realtobits(7.0), 64'h401C000000000000);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/uint8_to_float.md
Name: uint8_to_float

Overview:
- Converts an unsigned 8-bit pixel/channel value (0..255) into an IEEE-754 float of width SIZE.
- It is the return path of the float pixel pipeline. Quantised 8-bit values read from frame/texture memory enter here and go back into floating-point arithmetic.
- AXI-stream slave in, AXI-stream master out, in the same style as the other float operator blocks.
- Two-stage pipeline with full backpressure. The conversion is exact, so there is no rounding.

Parameters:
- SIZE, 64, output float width. Only 64 (binary64: EXP_W=11, MAN_W=52, BIAS=1023) and 32 (binary32: EXP_W=8, MAN_W=23, BIAS=127) are legal. Any other value is an elaboration error.

Ports:
- aclk  input  1  clock; all state on rising edge
- aresetn  input  1  reset, asynchronous assert, active-low
- s_axis_a_tdata  input  8  unsigned integer value to convert
- s_axis_a_tvalid  input  1  input beat valid
- s_axis_a_tready  output  1  block can accept input beat
- m_axis_result_tdata  output  SIZE  converted float
- m_axis_result_tvalid  output  1  result beat valid
- m_axis_result_tready  input  1  downstream accepts result

Behaviour:
- Reset (aresetn=0, asynchronous):
  - Stage valid flags v1 and v2 clear immediately, so m_axis_result_tvalid=0.
  - m_axis_result_tdata=0.
  - Stage data registers clear to 0.
  - s_axis_a_tready=1 once reset deasserts.
- Reset mid-operation: all in-flight beats are discarded and no partial result is emitted.
- Handshake:
  - A beat transfers on tvalid && tready at a rising edge.
  - m_axis_result_tdata is held stable while m_axis_result_tvalid=1 and m_axis_result_tready=0.
  - m_axis_result_tvalid never drops without a handshake.
- Pipeline advance:
  - adv2 = !v2 || m_axis_result_tready
  - adv1 = !v1 || adv2
  - s_axis_a_tready = adv1 (combinational from m_axis_result_tready; accepted).
- Stage 1, when adv1:
  - Capture the input value into d1.
  - Compute the leading-one position p1 (0..7) with a priority encoder.
  - Set z1 = (value==0).
  - v1 <= s_axis_a_tvalid.
- Stage 2, when adv2:
  - v2 <= v1.
  - Result = {sign=0, exp, man}.
  - exp = BIAS + p1, zero-extended to EXP_W.
  - man = (d1 << (8-p1))[7:0] placed in the top 8 bits of the MAN_W field, with the lower bits 0. This drops the implicit leading one.
  - If z1, the result is all zeros (+0.0).
- Latency and throughput:
  - 2 cycles from input handshake to m_axis_result_tvalid with no backpressure.
  - Throughput is 1 beat/cycle.
- Under backpressure:
  - Up to 2 beats are held internally.
  - Input and output handshakes may occur in the same cycle when full, because adv2 lets the pipeline shift.
  - Ordering is strictly preserved.
- Arithmetic:
  - Every 8-bit value is exactly representable in both formats, so no rounding or sticky logic is needed.
  - Sign is always 0.
  - No NaN, Inf or denormal outputs.
  - The maximum output is 255.0, which equals the upper bound used by the float clamp stage. The round trip clamp(convert(x)) is therefore the identity.

Decomposition:
- Shared package float_pkg:
  - Per-SIZE format constants EXP_W, MAN_W, BIAS.
  - Constant FLOAT_255 per format: 64'h406FE00000000000 and 32'h437F0000.
- One natural sub-module, lzc8: an 8-bit leading-one priority encoder with outputs pos[2:0] and zero.
- The pipeline control and float packing stay in uint8_to_float.

Test Plan:
- SIZE=64 streaming, m_axis_result_tready held at 1, inputs 0, 1, 3, 128, 255 on consecutive cycles:
  - Outputs 0x0, 0x3FF0000000000000, 0x4008000000000000, 0x4060000000000000, 0x406FE00000000000.
  - Each output appears 2 cycles after its input; tvalid stays high for 5 consecutive cycles.
- SIZE=32, inputs 1, 2, 255, 0 -> 0x3F800000, 0x40000000, 0x437F0000, 0x00000000.
- Backpressure:
  - Send 4 beats (10, 20, 30, 40) with m_axis_result_tready=0. s_axis_a_tready falls after 2 beats are accepted; the first output is held stable at 10.0 (0x4024000000000000).
  - Release tready. All 4 results emerge in order with no duplicates or drops.
- Random tvalid/tready toggling, all 256 input values:
  - A scoreboard checks every output bit-exactly against the real-to-bits reference.
  - It also checks that tdata is stable while tvalid && !tready.
- Reset mid-stream:
  - Assert aresetn=0 asynchronously (not aligned to a clock edge) with 2 beats in flight. m_axis_result_tvalid goes to 0 immediately.
  - After release, the next input 7 yields 0x401C000000000000 with no stale beat emitted.
- Full-pipeline simultaneous handshake: with v1=v2=1 and m_axis_result_tready=1, a new input is accepted in the same cycle as an output handshake, sustaining 1 beat/cycle.
